// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares the middleboard SPI bus between the core SPI slaves
// and the SD-card passthrough. Selects are synchronised, one owner is granted
// at a time, and a guard interval separates ownership changes.
module spi_bus_arbiter #(
    parameter int unsigned GUARD_CYCLES  = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          CORE_PRIORITY = 1'b1
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       spi_ss2_n,
    input  logic       spi_ss3_n,
    input  logic       conf_data0_n,
    input  logic       spi_ss4_n,
    output logic       grant_core,
    output logic       grant_sd,
    output logic       sck_sel_sd,
    output logic       miso_oe_sd,
    output logic       busy,
    output logic [1:0] state,
    output logic [7:0] conflict_cnt
);

    localparam int unsigned GW         = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int unsigned GUARD_LOAD = (GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CORE  = 2'b01,
        ST_SD    = 2'b10,
        ST_GUARD = 2'b11
    } state_t;

    state_t        state_q;
    logic [GW-1:0] guard_cnt;
    logic [3:0]    sync_q [SYNC_STAGES];
    logic [4:0]    outs_q;
    logic          req_core_q;
    logic          req_sd_q;
    logic          req_core_c;
    logic          req_sd_c;
    logic          conflict_inc_c;

    // Output bundle {busy, grant_core, grant_sd, sck_sel_sd, miso_oe_sd} for a state
    function automatic logic [4:0] decode(input state_t s);
        case (s)
            ST_CORE:  decode = 5'b1_1000;
            ST_SD:    decode = 5'b1_0111;
            ST_GUARD: decode = 5'b1_0000;
            default:  decode = 5'b0_0000;
        endcase
    endfunction

    // Synchroniser chains for all four selects; reset parks them deasserted
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= 4'hF;
        end else begin
            sync_q[0] <= {spi_ss4_n, conf_data0_n, spi_ss3_n, spi_ss2_n};
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign req_core_c = ~(sync_q[SYNC_STAGES-1][0] & sync_q[SYNC_STAGES-1][1] & sync_q[SYNC_STAGES-1][2]);
    assign req_sd_c   = ~sync_q[SYNC_STAGES-1][3];

    // Conflict events: simultaneous request from IDLE, or non-owner rising edge while owned
    always_comb begin
        conflict_inc_c = 1'b0;
        case (state_q)
            ST_IDLE: conflict_inc_c = req_core_c & req_sd_c;
            ST_CORE: conflict_inc_c = req_sd_c & ~req_sd_q;
            ST_SD:   conflict_inc_c = req_core_c & ~req_core_q;
            default: conflict_inc_c = 1'b0;
        endcase
    end

    // Ownership FSM with outputs registered alongside the state
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            outs_q       <= 5'b0;
            guard_cnt    <= '0;
            conflict_cnt <= 8'd0;
            req_core_q   <= 1'b0;
            req_sd_q     <= 1'b0;
        end else begin
            req_core_q <= req_core_c;
            req_sd_q   <= req_sd_c;
            if (conflict_inc_c && conflict_cnt != 8'hFF)
                conflict_cnt <= conflict_cnt + 8'd1;

            case (state_q)
                ST_IDLE: begin
                    if (req_core_c && (CORE_PRIORITY || !req_sd_c)) begin
                        state_q <= ST_CORE;
                        outs_q  <= decode(ST_CORE);
                    end else if (req_sd_c) begin
                        state_q <= ST_SD;
                        outs_q  <= decode(ST_SD);
                    end
                end
                ST_CORE: begin
                    if (!req_core_c) begin
                        if (GUARD_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                            outs_q  <= decode(ST_IDLE);
                        end else begin
                            state_q   <= ST_GUARD;
                            outs_q    <= decode(ST_GUARD);
                            guard_cnt <= GW'(GUARD_LOAD);
                        end
                    end
                end
                ST_SD: begin
                    if (!req_sd_c) begin
                        if (GUARD_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                            outs_q  <= decode(ST_IDLE);
                        end else begin
                            state_q   <= ST_GUARD;
                            outs_q    <= decode(ST_GUARD);
                            guard_cnt <= GW'(GUARD_LOAD);
                        end
                    end
                end
                default: begin
                    if (guard_cnt == '0) begin
                        state_q <= ST_IDLE;
                        outs_q  <= decode(ST_IDLE);
                    end else begin
                        guard_cnt <= guard_cnt - GW'(1);
                    end
                end
            endcase
        end
    end

    assign state      = state_q;
    assign busy       = outs_q[4];
    assign grant_core = outs_q[3];
    assign grant_sd   = outs_q[2];
    assign sck_sel_sd = outs_q[1];
    assign miso_oe_sd = outs_q[0];

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: stimulus pushes cycle-stamped
// expectations; a negedge monitor pops and compares them against the DUT.
module tb_spi_bus_arbiter;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       spi_ss2_n = 1'b1;
    logic       spi_ss3_n = 1'b1;
    logic       conf_data0_n = 1'b1;
    logic       spi_ss4_n = 1'b1;
    logic       grant_core, grant_sd, sck_sel_sd, miso_oe_sd, busy;
    logic [1:0] state;
    logic [7:0] conflict_cnt;

    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic        prev_gc = 1'b0;
    logic        prev_gs = 1'b0;

    typedef struct {
        int unsigned at;
        int          sel;
        logic [7:0]  val;
    } exp_t;
    exp_t exp_q[$];

    localparam int S_GC = 0, S_GS = 1, S_SCK = 2, S_MISO = 3, S_BUSY = 4, S_STATE = 5, S_CNT = 6;

    spi_bus_arbiter dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .spi_ss2_n    (spi_ss2_n),
        .spi_ss3_n    (spi_ss3_n),
        .conf_data0_n (conf_data0_n),
        .spi_ss4_n    (spi_ss4_n),
        .grant_core   (grant_core),
        .grant_sd     (grant_sd),
        .sck_sel_sd   (sck_sel_sd),
        .miso_oe_sd   (miso_oe_sd),
        .busy         (busy),
        .state        (state),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic string sel_name(input int sel);
        case (sel)
            S_GC:    sel_name = "grant_core";
            S_GS:    sel_name = "grant_sd";
            S_SCK:   sel_name = "sck_sel_sd";
            S_MISO:  sel_name = "miso_oe_sd";
            S_BUSY:  sel_name = "busy";
            S_STATE: sel_name = "state";
            default: sel_name = "conflict_cnt";
        endcase
    endfunction

    function automatic logic [7:0] get_val(input int sel);
        case (sel)
            S_GC:    get_val = {7'd0, grant_core};
            S_GS:    get_val = {7'd0, grant_sd};
            S_SCK:   get_val = {7'd0, sck_sel_sd};
            S_MISO:  get_val = {7'd0, miso_oe_sd};
            S_BUSY:  get_val = {7'd0, busy};
            S_STATE: get_val = {6'd0, state};
            default: get_val = conflict_cnt;
        endcase
    endfunction

    task automatic expect_at(input int unsigned at, input int sel, input logic [7:0] val);
        exp_t e;
        e.at  = at;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic wait_edge(input int unsigned n);
        while (cyc < n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Monitor: pops due expectations and checks grant exclusivity every cycle
    always @(negedge clk_sys) begin
        if (cyc >= 3) begin
            vectors++;
            if ((grant_core & grant_sd) === 1'b1 ||
                (prev_gc === 1'b1 && grant_sd === 1'b1) ||
                (prev_gs === 1'b1 && grant_core === 1'b1)) begin
                miscompares++;
                $display("FAIL exclusive_grant cycle %0d: gc=%b gs=%b prev_gc=%b prev_gs=%b",
                         cyc, grant_core, grant_sd, prev_gc, prev_gs);
            end
            prev_gc = grant_core;
            prev_gs = grant_sd;
        end
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            exp_t e;
            logic [7:0] got;
            e = exp_q.pop_front();
            vectors++;
            got = get_val(e.sel);
            if (e.at != cyc) begin
                miscompares++;
                $display("FAIL %s expectation for cycle %0d reached at cycle %0d", sel_name(e.sel), e.at, cyc);
            end else if (got !== e.val) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %0d expected %0d", sel_name(e.sel), cyc, got, e.val);
            end
        end
    end

    initial begin
        // Reset and idle
        expect_at(5, S_STATE, 8'd0);
        expect_at(5, S_GC, 8'd0);
        expect_at(5, S_GS, 8'd0);
        expect_at(5, S_MISO, 8'd0);
        expect_at(5, S_CNT, 8'd0);
        expect_at(22, S_STATE, 8'd0);
        expect_at(22, S_BUSY, 8'd0);
        expect_at(22, S_CNT, 8'd0);
        wait_edge(2);
        reset = 1'b0;

        // Core grant/release via OSD select
        wait_edge(40);
        spi_ss3_n = 1'b0;
        expect_at(42, S_GC, 8'd0);
        expect_at(43, S_GC, 8'd1);
        expect_at(43, S_STATE, 8'd1);
        expect_at(43, S_BUSY, 8'd1);
        expect_at(43, S_MISO, 8'd0);
        expect_at(43, S_SCK, 8'd0);
        expect_at(62, S_GC, 8'd1);
        expect_at(63, S_GC, 8'd0);
        expect_at(63, S_STATE, 8'd3);
        expect_at(66, S_STATE, 8'd3);
        expect_at(66, S_BUSY, 8'd1);
        expect_at(67, S_STATE, 8'd0);
        expect_at(67, S_BUSY, 8'd0);
        wait_edge(60);
        spi_ss3_n = 1'b1;

        // SD passthrough alone
        wait_edge(80);
        spi_ss4_n = 1'b0;
        expect_at(82, S_GS, 8'd0);
        expect_at(83, S_GS, 8'd1);
        expect_at(83, S_SCK, 8'd1);
        expect_at(83, S_MISO, 8'd1);
        expect_at(83, S_STATE, 8'd2);
        expect_at(93, S_GS, 8'd0);
        expect_at(93, S_SCK, 8'd0);
        expect_at(93, S_MISO, 8'd0);
        expect_at(93, S_STATE, 8'd3);
        expect_at(97, S_STATE, 8'd0);
        wait_edge(90);
        spi_ss4_n = 1'b1;

        // Simultaneous request: core wins, SD follows after guard
        wait_edge(110);
        conf_data0_n = 1'b0;
        spi_ss4_n    = 1'b0;
        expect_at(113, S_GC, 8'd1);
        expect_at(113, S_GS, 8'd0);
        expect_at(113, S_CNT, 8'd1);
        expect_at(113, S_STATE, 8'd1);
        expect_at(123, S_STATE, 8'd3);
        expect_at(126, S_STATE, 8'd3);
        expect_at(127, S_STATE, 8'd0);
        expect_at(127, S_GS, 8'd0);
        expect_at(128, S_GS, 8'd1);
        expect_at(128, S_STATE, 8'd2);
        expect_at(128, S_CNT, 8'd1);
        wait_edge(120);
        conf_data0_n = 1'b1;

        // Conflict storm while SD owns the bus
        wait_edge(130);
        expect_at(133, S_CNT, 8'd2);
        expect_at(133, S_GS, 8'd1);
        expect_at(1141, S_CNT, 8'd254);
        expect_at(1145, S_CNT, 8'd255);
        expect_at(1145, S_GS, 8'd1);
        expect_at(1335, S_CNT, 8'd255);
        expect_at(1335, S_GS, 8'd1);
        expect_at(1335, S_GC, 8'd0);
        expect_at(1335, S_STATE, 8'd2);
        for (int k = 0; k < 300; k++) begin
            wait_edge(130 + 4 * k);
            spi_ss2_n = 1'b0;
            wait_edge(132 + 4 * k);
            spi_ss2_n = 1'b1;
        end

        // Mid-transfer reset while core owns the bus
        wait_edge(1340);
        spi_ss4_n = 1'b1;
        expect_at(1343, S_STATE, 8'd3);
        expect_at(1347, S_STATE, 8'd0);
        expect_at(1353, S_GC, 8'd1);
        expect_at(1361, S_GC, 8'd0);
        expect_at(1361, S_STATE, 8'd0);
        expect_at(1361, S_CNT, 8'd0);
        expect_at(1363, S_GC, 8'd0);
        expect_at(1364, S_GC, 8'd1);
        expect_at(1364, S_STATE, 8'd1);
        wait_edge(1350);
        spi_ss2_n = 1'b0;
        wait_edge(1360);
        reset = 1'b1;
        wait_edge(1361);
        reset = 1'b0;

        // Drain the scoreboard with a bounded wait
        wait_edge(1370);
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk_sys);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
